// File: rtl/decode_execute_reg.sv
// Decode/execute pipeline register with load-use hazard detection,
// flush/stall priority and a saturating bubble counter.
module decode_execute_reg #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic [1:0]        id_branch_i,
  input  logic [1:0]        id_alusrc_i,
  input  logic [1:0]        id_aluop_i,
  input  logic              id_resultsrc_i,
  input  logic              id_regsrc_i,
  input  logic              id_regwrite_i,
  input  logic              id_memwrite_i,
  input  logic [DATA_W-1:0] id_rd1_i,
  input  logic [DATA_W-1:0] id_rd2_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [DATA_W-1:0] id_pc_i,
  input  logic [4:0]        id_rs1_i,
  input  logic [4:0]        id_rs2_i,
  input  logic [4:0]        id_rd_i,
  input  logic [2:0]        id_funct3_i,
  input  logic              flush_i,
  input  logic              stall_i,
  output logic              ex_valid_o,
  output logic [1:0]        ex_branch_o,
  output logic [1:0]        ex_alusrc_o,
  output logic [1:0]        ex_aluop_o,
  output logic              ex_resultsrc_o,
  output logic              ex_regsrc_o,
  output logic              ex_regwrite_o,
  output logic              ex_memwrite_o,
  output logic [DATA_W-1:0] ex_rd1_o,
  output logic [DATA_W-1:0] ex_rd2_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [DATA_W-1:0] ex_pc_o,
  output logic [4:0]        ex_rs1_o,
  output logic [4:0]        ex_rs2_o,
  output logic [4:0]        ex_rd_o,
  output logic [2:0]        ex_funct3_o,
  output logic              stall_o,
  output logic [15:0]       bubble_cnt_o
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned REG_W = 5;
  localparam int unsigned F3_W  = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [1:0] branch;
    logic [1:0] alusrc;
    logic [1:0] aluop;
    logic       resultsrc;
    logic       regsrc;
    logic       regwrite;
    logic       memwrite;
  } ctrl_t;

  typedef struct packed {
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [F3_W-1:0]   funct3;
  } data_t;

  logic             valid_q, valid_d;
  ctrl_t            ctrl_q, ctrl_d;
  data_t            data_q, data_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic             hazard_c;
  ctrl_t            id_ctrl;
  data_t            id_data;

  assign id_ctrl = '{branch: id_branch_i, alusrc: id_alusrc_i, aluop: id_aluop_i,
                     resultsrc: id_resultsrc_i, regsrc: id_regsrc_i,
                     regwrite: id_regwrite_i, memwrite: id_memwrite_i};
  assign id_data = '{rd1: id_rd1_i, rd2: id_rd2_i, imm: id_imm_i, pc: id_pc_i,
                     rs1: id_rs1_i, rs2: id_rs2_i, rd: id_rd_i, funct3: id_funct3_i};

  // Load in EX whose destination is read by the instruction in decode
  assign hazard_c = valid_q && ctrl_q.resultsrc && ctrl_q.regwrite &&
                    (data_q.rd != '0) && id_valid_i &&
                    ((data_q.rd == id_rs1_i) || (data_q.rd == id_rs2_i));

  assign stall_o = hazard_c | stall_i;

  // Next-state selection: flush > stall > bubble > advance
  always_comb begin
    valid_d      = valid_q;
    ctrl_d       = ctrl_q;
    data_d       = data_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (stall_i) begin
      valid_d = valid_q;
    end else if (hazard_c) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (bubble_cnt_q != CNT_MAX) begin
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
    end else begin
      valid_d = id_valid_i;
      ctrl_d  = id_valid_i ? id_ctrl : '0;
      data_d  = id_data;
    end
  end

  // Pipeline state, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      ctrl_q       <= '0;
      data_q       <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      ctrl_q       <= ctrl_d;
      data_q       <= data_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid_o     = valid_q;
  assign ex_branch_o    = ctrl_q.branch;
  assign ex_alusrc_o    = ctrl_q.alusrc;
  assign ex_aluop_o     = ctrl_q.aluop;
  assign ex_resultsrc_o = ctrl_q.resultsrc;
  assign ex_regsrc_o    = ctrl_q.regsrc;
  assign ex_regwrite_o  = ctrl_q.regwrite;
  assign ex_memwrite_o  = ctrl_q.memwrite;
  assign ex_rd1_o       = data_q.rd1;
  assign ex_rd2_o       = data_q.rd2;
  assign ex_imm_o       = data_q.imm;
  assign ex_pc_o        = data_q.pc;
  assign ex_rs1_o       = data_q.rs1;
  assign ex_rs2_o       = data_q.rs2;
  assign ex_rd_o        = data_q.rd;
  assign ex_funct3_o    = data_q.funct3;
  assign bubble_cnt_o   = bubble_cnt_q;

endmodule

// File: tb/tb_decode_execute_reg.sv
// Bench for decode_execute_reg: instruction-level model plus directed cases.
module tb_decode_execute_reg;

  typedef struct packed {
    logic        valid;
    logic [1:0]  branch;
    logic [1:0]  alusrc;
    logic [1:0]  aluop;
    logic        resultsrc;
    logic        regsrc;
    logic        regwrite;
    logic        memwrite;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
  } instr_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush, stall, preload;
  instr_t id;

  logic        ex_valid, ex_resultsrc, ex_regsrc, ex_regwrite, ex_memwrite, stall_o;
  logic [1:0]  ex_branch, ex_alusrc, ex_aluop;
  logic [31:0] ex_rd1, ex_rd2, ex_imm, ex_pc;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic [15:0] bubble_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_execute_reg #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id.valid),
    .id_branch_i(id.branch), .id_alusrc_i(id.alusrc), .id_aluop_i(id.aluop),
    .id_resultsrc_i(id.resultsrc), .id_regsrc_i(id.regsrc),
    .id_regwrite_i(id.regwrite), .id_memwrite_i(id.memwrite),
    .id_rd1_i(id.rd1), .id_rd2_i(id.rd2), .id_imm_i(id.imm), .id_pc_i(id.pc),
    .id_rs1_i(id.rs1), .id_rs2_i(id.rs2), .id_rd_i(id.rd), .id_funct3_i(id.funct3),
    .flush_i(flush), .stall_i(stall),
    .ex_valid_o(ex_valid), .ex_branch_o(ex_branch), .ex_alusrc_o(ex_alusrc),
    .ex_aluop_o(ex_aluop), .ex_resultsrc_o(ex_resultsrc), .ex_regsrc_o(ex_regsrc),
    .ex_regwrite_o(ex_regwrite), .ex_memwrite_o(ex_memwrite),
    .ex_rd1_o(ex_rd1), .ex_rd2_o(ex_rd2), .ex_imm_o(ex_imm), .ex_pc_o(ex_pc),
    .ex_rs1_o(ex_rs1), .ex_rs2_o(ex_rs2), .ex_rd_o(ex_rd), .ex_funct3_o(ex_funct3),
    .stall_o(stall_o), .bubble_cnt_o(bubble_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // An instruction that never reached EX keeps its operands but loses all effects
  function automatic instr_t squash(input instr_t i);
    instr_t r = i;
    r.valid = 1'b0; r.branch = '0; r.alusrc = '0; r.aluop = '0;
    r.resultsrc = 1'b0; r.regsrc = 1'b0; r.regwrite = 1'b0; r.memwrite = 1'b0;
    return r;
  endfunction

  // Consumer in decode needs a value that a load in EX has not produced yet
  function automatic bit load_use(input instr_t ex_i, input instr_t id_i);
    bit is_load = ex_i.valid && ex_i.resultsrc && ex_i.regwrite && ex_i.rd != 0;
    return is_load && id_i.valid && (id_i.rs1 == ex_i.rd || id_i.rs2 == ex_i.rd);
  endfunction

  function automatic instr_t mk(input bit v, input bit ld, input bit wr, input bit st,
                                input logic [1:0] aluop, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd);
    instr_t r = '0;
    r.valid = v; r.resultsrc = ld; r.regwrite = wr; r.memwrite = st; r.aluop = aluop;
    r.alusrc = ld | st ? 2'b01 : 2'b00; r.regsrc = ld; r.branch = 2'b00;
    r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.funct3 = 3'(rd);
    r.rd1 = 32'hA000_0000 | 32'(rs1); r.rd2 = 32'hB000_0000 | 32'(rs2);
    r.imm = 32'h0000_0100 + 32'(rd); r.pc = 32'h8000_0000 + {25'd0, rd, 2'b00};
    return r;
  endfunction

  // Reference model: what sits in EX and how many bubbles were counted
  instr_t m_ex;
  logic [15:0] m_cnt;
  int m_next;
  always @(posedge clk or negedge rst_n or posedge preload) begin
    if (!rst_n) begin
      m_ex  <= '0;
      m_cnt <= '0;
    end else if (preload) begin
      m_cnt <= 16'hFFFE;
    end else if (flush) begin
      m_ex <= squash(m_ex);
    end else if (stall) begin
      m_ex <= m_ex;
    end else if (load_use(m_ex, id)) begin
      m_ex   <= squash(m_ex);
      m_next = int'(m_cnt) + 1;
      m_cnt  <= (m_next > 65535) ? 16'hFFFF : 16'(m_next);
    end else begin
      m_ex <= id.valid ? id : squash(id);
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    check("m.valid", 64'(ex_valid), 64'(m_ex.valid));
    check("m.ctrl", 64'({ex_branch, ex_alusrc, ex_aluop, ex_resultsrc, ex_regsrc, ex_regwrite, ex_memwrite}),
          64'({m_ex.branch, m_ex.alusrc, m_ex.aluop, m_ex.resultsrc, m_ex.regsrc, m_ex.regwrite, m_ex.memwrite}));
    check("m.rd1", 64'(ex_rd1), 64'(m_ex.rd1));
    check("m.rd2", 64'(ex_rd2), 64'(m_ex.rd2));
    check("m.imm", 64'(ex_imm), 64'(m_ex.imm));
    check("m.pc", 64'(ex_pc), 64'(m_ex.pc));
    check("m.idx", 64'({ex_rs1, ex_rs2, ex_rd, ex_funct3}), 64'({m_ex.rs1, m_ex.rs2, m_ex.rd, m_ex.funct3}));
    check("m.bubble_cnt", 64'(bubble_cnt), 64'(m_cnt));
    check("m.stall_o", 64'(stall_o), 64'(load_use(m_ex, id) | stall));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_pair(input logic [4:0] r);
    id = mk(1, 1, 1, 0, 2'b00, 5'd2, 5'd0, r);
    cyc();
    id = mk(1, 0, 1, 0, 2'b10, r, 5'd3, 5'd6);
    cyc();
    cyc();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; stall = 1'b0; preload = 1'b0; id = '0;
    #2;
    check("reset.valid", 64'(ex_valid), 64'd0);
    check("reset.cnt", 64'(bubble_cnt), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Plain R-type add
    id = mk(1, 0, 1, 0, 2'b10, 5'd1, 5'd2, 5'd5);
    cyc();
    check("add.regwrite", 64'(ex_regwrite), 64'd1);
    check("add.aluop", 64'(ex_aluop), 64'd2);
    check("add.rd", 64'(ex_rd), 64'd5);
    #1 check("add.stall_o", 64'(stall_o), 64'd0);

    // Load-use on x5
    id = mk(1, 1, 1, 0, 2'b00, 5'd2, 5'd0, 5'd5);
    cyc();
    id = mk(1, 0, 1, 0, 2'b10, 5'd5, 5'd3, 5'd6);
    #1 check("lu.stall_o_hi", 64'(stall_o), 64'd1);
    cyc();
    check("lu.bubble_valid", 64'(ex_valid), 64'd0);
    check("lu.bubble_regwrite", 64'(ex_regwrite), 64'd0);
    check("lu.cnt", 64'(bubble_cnt), 64'd1);
    check("lu.rd_held", 64'(ex_rd), 64'd5);
    #1 check("lu.stall_o_lo", 64'(stall_o), 64'd0);
    cyc();
    check("lu.add_rd", 64'(ex_rd), 64'd6);
    check("lu.add_valid", 64'(ex_valid), 64'd1);

    // Load to x0 never stalls
    id = mk(1, 1, 1, 0, 2'b00, 5'd2, 5'd0, 5'd0);
    cyc();
    id = mk(1, 0, 1, 0, 2'b10, 5'd0, 5'd3, 5'd7);
    #1 check("x0.stall_o", 64'(stall_o), 64'd0);
    cyc();
    check("x0.cnt", 64'(bubble_cnt), 64'd1);
    check("x0.consumer_rd", 64'(ex_rd), 64'd7);

    // Flush beats hazard
    id = mk(1, 1, 1, 0, 2'b00, 5'd1, 5'd0, 5'd7);
    cyc();
    id = mk(1, 0, 1, 0, 2'b10, 5'd1, 5'd7, 5'd8);
    flush = 1'b1;
    #1 check("fh.stall_o", 64'(stall_o), 64'd1);
    cyc();
    flush = 1'b0;
    check("fh.valid", 64'(ex_valid), 64'd0);
    check("fh.cnt", 64'(bubble_cnt), 64'd1);
    check("fh.rd_kept", 64'(ex_rd), 64'd7);

    // Flush beats stall
    id = mk(1, 0, 0, 1, 2'b00, 5'd4, 5'd9, 5'd0);
    cyc();
    check("st.memwrite", 64'(ex_memwrite), 64'd1);
    id = mk(1, 0, 1, 0, 2'b10, 5'd1, 5'd2, 5'd11);
    flush = 1'b1; stall = 1'b1;
    cyc();
    flush = 1'b0; stall = 1'b0;
    check("fs.memwrite", 64'(ex_memwrite), 64'd0);
    check("fs.valid", 64'(ex_valid), 64'd0);

    // Stall holds EX
    id = mk(1, 0, 1, 0, 2'b10, 5'd1, 5'd2, 5'd9);
    cyc();
    id = mk(1, 0, 1, 0, 2'b01, 5'd3, 5'd4, 5'd10);
    stall = 1'b1;
    cyc();
    cyc();
    check("stall.rd_held", 64'(ex_rd), 64'd9);
    check("stall.aluop_held", 64'(ex_aluop), 64'd2);
    stall = 1'b0;
    cyc();
    check("stall.release_rd", 64'(ex_rd), 64'd10);

    // Invalid slot advances data but no control
    id = mk(0, 1, 1, 1, 2'b11, 5'd12, 5'd13, 5'd14);
    cyc();
    check("inv.valid", 64'(ex_valid), 64'd0);
    check("inv.regwrite", 64'(ex_regwrite), 64'd0);
    check("inv.rd", 64'(ex_rd), 64'd14);

    // Saturation from a preloaded counter
    id = '0;
    force dut.bubble_cnt_q = 16'hFFFE;
    preload = 1'b1;
    #1 preload = 1'b0;
    cyc();
    release dut.bubble_cnt_q;
    for (int k = 0; k < 3; k++) load_use_pair(5'(k + 5));
    check("sat.cnt", 64'(bubble_cnt), 64'hFFFF);

    // Asynchronous reset between edges
    id = mk(1, 0, 1, 0, 2'b10, 5'd1, 5'd2, 5'd5);
    cyc();
    check("ar.valid_before", 64'(ex_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar.valid", 64'(ex_valid), 64'd0);
    check("ar.regwrite", 64'(ex_regwrite), 64'd0);
    check("ar.rd", 64'(ex_rd), 64'd0);
    check("ar.cnt", 64'(bubble_cnt), 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("ar.first_edge_valid", 64'(ex_valid), 64'd1);
    check("ar.first_edge_rd", 64'(ex_rd), 64'd5);
    id = '0;
    cyc();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_execute_reg.md
DECODE_EXECUTE_REG -- requirements
Module: decode_execute_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the operand, immediate and PC fields.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port id_valid_i, input, 1 bit: the decode slot holds a real instruction.
REQ-005 SHALL have ports id_branch_i (2), id_alusrc_i (2), id_aluop_i (2), id_resultsrc_i (1), id_regsrc_i (1), id_regwrite_i (1) and id_memwrite_i (1), all inputs: the main-decoder control fields.
REQ-006 SHALL have ports id_rd1_i, id_rd2_i, id_imm_i and id_pc_i, inputs, DATA_W each: the register-file read data, the extended immediate and the PC.
REQ-007 SHALL have ports id_rs1_i, id_rs2_i and id_rd_i (5 each) and id_funct3_i (3), all inputs: register indices and funct3.
REQ-008 SHALL have port flush_i, input, 1 bit: a taken branch or jump in EX; kill the incoming instruction.
REQ-009 SHALL have port stall_i, input, 1 bit: a downstream (memory) stall; hold all state.
REQ-010 SHALL have ex_* outputs: registered copies of every field in REQ-005 to REQ-007, plus ex_valid_o (1 bit).
REQ-011 SHALL have port stall_o, output, 1 bit: the fetch stage and IF/ID register must hold.
REQ-012 SHALL have port bubble_cnt_o, output, 16 bits: saturating count of load-use bubbles inserted.

Function
REQ-013 SHALL compute hazard combinationally; it is 1 only when all of the following hold:
- ex_valid_o, ex_resultsrc_o and ex_regwrite_o are all 1;
- ex_rd_o != 0;
- id_valid_i is 1;
- ex_rd_o == id_rs1_i or ex_rd_o == id_rs2_i.
REQ-014 SHALL drive stall_o = hazard OR stall_i, combinationally.
REQ-015 SHALL apply the following per-edge priority; only the highest-priority true case takes effect:
- (1) flush_i;
- (2) stall_i;
- (3) hazard;
- (4) normal advance.
REQ-016 When flush_i=1, SHALL clear all of the following and leave the data and index fields unchanged:
- ex_valid_o;
- ex_regwrite_o, ex_memwrite_o, ex_branch_o;
- ex_resultsrc_o, ex_regsrc_o;
- ex_aluop_o, ex_alusrc_o.
REQ-017 When stall_i=1 and flush_i=0, SHALL hold every ex_* output and bubble_cnt_o unchanged.
REQ-018 On hazard (no flush, no stall_i), SHALL insert a bubble: clear the same fields as REQ-016, hold the data fields, and increment bubble_cnt_o by 1.
REQ-019 SHALL saturate bubble_cnt_o at 16'hFFFF; it never wraps.
REQ-020 On normal advance, SHALL load every id_* field into its ex_* register and set ex_valid_o = id_valid_i.
REQ-021 On normal advance with id_valid_i=0, SHALL force all control outputs to 0.
REQ-022 SHALL ensure a hazard lasts at most one cycle per load, because the bubble clears ex_valid_o.
REQ-023 A flush arriving in the same cycle as a hazard SHALL win: no bubble is counted and stall_o still reflects the hazard that cycle.
REQ-024 Latency: SHALL present decode fields on the ex_* outputs exactly one cycle after capture; there is no combinational path from id_* to ex_*.

Reset
REQ-025 While rst_n=0, SHALL immediately, without waiting for a clock edge, force every ex_* output and bubble_cnt_o to 0, ex_valid_o included.
REQ-026 Reset asserted mid-stall or mid-bubble SHALL discard that state entirely.
REQ-027 On the first edge after rst_n rises, SHALL behave as a normal-advance edge.

Verification
REQ-028 Plain pipeline: R-type add (regwrite=1, aluop=10, rd=5) with id_valid=1 -> one cycle later ex_regwrite_o=1, ex_aluop_o=10, ex_rd_o=5, stall_o=0.
REQ-029 Load-use:
- Stimulus: lw to x5 (resultsrc=1, regwrite=1) followed by add with rs1=5.
- Response: stall_o=1 for exactly one cycle; ex_valid_o=0 and ex_regwrite_o=0 for one cycle; bubble_cnt_o=1; the add appears on the next cycle.
REQ-030 rd=x0 load: lw to x0 followed by a consumer with rs1=0 -> stall_o=0 and bubble_cnt_o unchanged.
REQ-031 Priority:
- flush_i=1 with a hazard present -> ex_valid_o=0 and bubble_cnt_o unchanged.
- flush_i=1 with stall_i=1 -> flush wins; ex_memwrite_o=0.
REQ-032 Saturation: preload bubble_cnt_o to 16'hFFFE, then apply 3 load-use pairs -> bubble_cnt_o reads 16'hFFFF.
REQ-033 Async reset: drop rst_n between clock edges while ex_valid_o=1 -> all outputs read 0 before the next edge.
